// File: rtl/reg_file_pkg.sv
// reg_file shared definitions: write-port op encoding.
// Imported by reg_cell and reg_file.
package reg_file_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_LOAD = 2'b01;
  localparam op_t OP_INC  = 2'b10;
  localparam op_t OP_DEC  = 2'b11;

  function automatic logic is_write(op_t op);
    return op != OP_HOLD;
  endfunction

endpackage

// File: rtl/reg_file_reg_cell.sv
// reg_cell: one WIDTH-bit register with load/inc/dec.
// nxt/wrap show the post-op value for the current op.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES = '1;

  // post-op value and wrap flag, ahead of the edge
  always_comb begin
    nxt  = q;
    wrap = 1'b0;
    unique case (op)
      OP_LOAD: nxt = din;
      OP_INC: begin
        nxt  = q + ONE;
        wrap = (q == ONES);
      end
      OP_DEC: begin
        nxt  = q - ONE;
        wrap = (q == '0);
      end
      default: nxt = q;
    endcase
  end

  // storage: clear on reset, commit when selected
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH registers, one op port, two read ports.
// Define REG_FILE_BYPASS_EN for write-through forwarding on reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid,
  output logic             wrap,
  output logic             zero
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [WIDTH-1:0] q    [DEPTH];
  logic [WIDTH-1:0] nxt  [DEPTH];
  logic [DEPTH-1:0] cwrap;
  logic [DEPTH-1:0] en;

  logic             wr_hit;
  logic [WIDTH-1:0] wr_val;
  logic             wr_wrap;
  logic [WIDTH-1:0] rdv_a;
  logic [WIDTH-1:0] rdv_b;

  // out-of-range targets and HOLD touch nothing
  assign wr_hit = is_write(op) &&
                  (int'(wr_addr) < DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign en[i] = wr_hit && (wr_addr == AW'(i));

    reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clock(clock),
      .reset(reset),
      .en   (en[i]),
      .op   (op),
      .din  (wr_data),
      .q    (q[i]),
      .nxt  (nxt[i]),
      .wrap (cwrap[i])
    );
  end

  // result of the op on the selected register
  always_comb begin
    wr_val  = '0;
    wr_wrap = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en[i]) begin
        wr_val  = nxt[i];
        wr_wrap = cwrap[i];
      end
    end
  end

  // read mux A: 0 when out of range, forward if enabled
  always_comb begin
    rdv_a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == AW'(i)) begin
        rdv_a = (BYPASS && en[i]) ? nxt[i] : q[i];
      end
    end
  end

  // read mux B: same rules as port A
  always_comb begin
    rdv_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_b == AW'(i)) begin
        rdv_b = (BYPASS && en[i]) ? nxt[i] : q[i];
      end
    end
  end

  // output registers: read data, valid, wrap/zero flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
      wrap      <= 1'b0;
      zero      <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data_a <= rdv_a;
        rd_data_b <= rdv_b;
      end
      wrap <= wr_hit && wr_wrap;
      if (wr_hit) begin
        zero <= (wr_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed + randomized checks of reg_file
// against an array-based reference model (three configs).
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // default config: WIDTH 8, DEPTH 8
  logic       rst1, re1, vld1, wrp1, zr1;
  logic [1:0] op1;
  logic [2:0] wa1, ra1, rb1;
  logic [7:0] wd1, da1, db1;

  reg_file u_dut1 (
    .clock(clock), .reset(rst1), .op(op1),
    .wr_addr(wa1), .wr_data(wd1), .rd_en(re1),
    .rd_addr_a(ra1), .rd_addr_b(rb1),
    .rd_data_a(da1), .rd_data_b(db1),
    .rd_valid(vld1), .wrap(wrp1), .zero(zr1)
  );

  // DEPTH 6: addresses 6 and 7 out of range
  logic       rst6, re6, vld6, wrp6, zr6;
  logic [1:0] op6;
  logic [2:0] wa6, ra6, rb6;
  logic [7:0] wd6, da6, db6;

  reg_file #(.WIDTH(8), .DEPTH(6)) u_dut6 (
    .clock(clock), .reset(rst6), .op(op6),
    .wr_addr(wa6), .wr_data(wd6), .rd_en(re6),
    .rd_addr_a(ra6), .rd_addr_b(rb6),
    .rd_data_a(da6), .rd_data_b(db6),
    .rd_valid(vld6), .wrap(wrp6), .zero(zr6)
  );

  // WIDTH 16, DEPTH 4
  logic        rstw, rew, vldw, wrpw, zrw;
  logic [1:0]  opw;
  logic [1:0]  waw, raw, rbw;
  logic [15:0] wdw, daw, dbw;

  reg_file #(.WIDTH(16), .DEPTH(4)) u_dutw (
    .clock(clock), .reset(rstw), .op(opw),
    .wr_addr(waw), .wr_data(wdw), .rd_en(rew),
    .rd_addr_a(raw), .rd_addr_b(rbw),
    .rd_data_a(daw), .rd_data_b(dbw),
    .rd_valid(vldw), .wrap(wrpw), .zero(zrw)
  );

  // reference model, one slot per DUT
  longint mm [3][32];
  longint era [3];
  longint erb [3];
  bit     ev [3];
  bit     ew [3];
  bit     ez [3];

  function automatic longint pick(int id, int d, int x,
                                  bit act, int a, longint nv);
    if (x >= d) return 0;
    if (BYP && act && x == a) return nv;
    return mm[id][x];
  endfunction

  task automatic mstep(input int id, input int w, input int d,
                       input bit r, input int o, input int a,
                       input int dd, input bit e,
                       input int x, input int y);
    longint md;
    longint old;
    longint nv;
    bit     act;
    md = longint'(1) << w;
    if (r) begin
      for (int i = 0; i < 32; i++) mm[id][i] = 0;
      era[id] = 0; erb[id] = 0;
      ev[id] = 0; ew[id] = 0; ez[id] = 1;
      return;
    end
    act = (o != 0) && (a < d);
    old = act ? mm[id][a] : 0;
    case (o)
      1: nv = longint'(dd) % md;
      2: nv = (old + 1) % md;
      3: nv = (old + md - 1) % md;
      default: nv = old;
    endcase
    ev[id] = e;
    if (e) begin
      era[id] = pick(id, d, x, act, a, nv);
      erb[id] = pick(id, d, y, act, a, nv);
    end
    ew[id] = act && ((o == 2 && old == md - 1) ||
                     (o == 3 && old == 0));
    if (act) begin
      ez[id] = (nv == 0);
      mm[id][a] = nv;
    end
  endtask

  task automatic drv1(input bit r, input int o, input int a,
                      input int d, input bit e,
                      input int x, input int y);
    rst1 = r; op1 = o[1:0]; wa1 = a[2:0]; wd1 = d[7:0];
    re1 = e; ra1 = x[2:0]; rb1 = y[2:0];
    mstep(0, 8, 8, r, o, a, d, e, x, y);
    @(posedge clock);
    #1;
  endtask

  task automatic drv6(input bit r, input int o, input int a,
                      input int d, input bit e,
                      input int x, input int y);
    rst6 = r; op6 = o[1:0]; wa6 = a[2:0]; wd6 = d[7:0];
    re6 = e; ra6 = x[2:0]; rb6 = y[2:0];
    mstep(1, 8, 6, r, o, a, d, e, x, y);
    @(posedge clock);
    #1;
  endtask

  task automatic drvw(input bit r, input int o, input int a,
                      input int d, input bit e,
                      input int x, input int y);
    rstw = r; opw = o[1:0]; waw = a[1:0]; wdw = d[15:0];
    rew = e; raw = x[1:0]; rbw = y[1:0];
    mstep(2, 16, 4, r, o, a, d, e, x, y);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    drv1(1, 0, 0, 0, 0, 0, 0);
    drv1(0, 1, 0, 'h77, 0, 0, 0);
    drv1(0, 0, 0, 0, 1, 0, 0);
    total++;
    if (da1 !== 8'h77) begin
      bad++; $display("FAIL pre_reset_load got %h want 77", da1);
    end
    drv1(1, 1, 0, 'h55, 1, 0, 0);
    total++;
    if ({da1, db1, vld1, wrp1, zr1} !== {8'h0, 8'h0, 3'b001}) begin
      bad++;
      $display("FAIL reset_outs got %h/%h v%b w%b z%b want 0/0 v0 w0 z1",
               da1, db1, vld1, wrp1, zr1);
    end
    drv1(0, 0, 0, 0, 1, 0, 0);
    total++;
    if (da1 !== 8'h00 || vld1 !== 1'b1) begin
      bad++; $display("FAIL reset_reg0 got %h v%b want 00 v1", da1, vld1);
    end
  endtask

  task automatic test_load_read;
    drv1(0, 1, 3, 'hA5, 0, 0, 0);
    total++;
    if (vld1 !== 1'b0) begin
      bad++; $display("FAIL early_valid got %b want 0", vld1);
    end
    drv1(0, 0, 0, 0, 1, 3, 3);
    total++;
    if (da1 !== 8'hA5 || db1 !== 8'hA5 || vld1 !== 1'b1) begin
      bad++; $display("FAIL load_read got %h/%h v%b want a5/a5 v1",
                      da1, db1, vld1);
    end
    drv1(0, 0, 0, 0, 0, 1, 1);
    total++;
    if (da1 !== 8'hA5 || vld1 !== 1'b0) begin
      bad++; $display("FAIL read_hold got %h v%b want a5 v0", da1, vld1);
    end
  endtask

  task automatic test_wrap;
    drv1(0, 1, 1, 'hFF, 0, 0, 0);
    total++;
    if (wrp1 !== 1'b0 || zr1 !== 1'b0) begin
      bad++; $display("FAIL load_ff_flags got w%b z%b want w0 z0", wrp1, zr1);
    end
    drv1(0, 2, 1, 0, 0, 0, 0);
    total++;
    if (wrp1 !== 1'b1 || zr1 !== 1'b1) begin
      bad++; $display("FAIL inc_wrap got w%b z%b want w1 z1", wrp1, zr1);
    end
    drv1(0, 0, 0, 0, 1, 1, 0);
    total++;
    if (da1 !== 8'h00 || wrp1 !== 1'b0 || zr1 !== 1'b1) begin
      bad++; $display("FAIL inc_after got %h w%b z%b want 00 w0 z1",
                      da1, wrp1, zr1);
    end
    drv1(0, 3, 1, 0, 0, 0, 0);
    total++;
    if (wrp1 !== 1'b1 || zr1 !== 1'b0) begin
      bad++; $display("FAIL dec_wrap got w%b z%b want w1 z0", wrp1, zr1);
    end
    drv1(0, 0, 0, 0, 1, 1, 0);
    total++;
    if (da1 !== 8'hFF || wrp1 !== 1'b0) begin
      bad++; $display("FAIL dec_after got %h w%b want ff w0", da1, wrp1);
    end
  endtask

  task automatic test_same_cycle;
    logic [7:0] want;
    drv1(0, 1, 2, 'h11, 0, 0, 0);
    drv1(0, 1, 2, 'h3C, 1, 2, 0);
    want = BYP ? 8'h3C : 8'h11;
    total++;
    if (da1 !== want) begin
      bad++; $display("FAIL rw_load got %h want %h", da1, want);
    end
    drv1(0, 2, 2, 0, 1, 0, 2);
    want = BYP ? 8'h3D : 8'h3C;
    total++;
    if (db1 !== want) begin
      bad++; $display("FAIL rw_inc got %h want %h", db1, want);
    end
    drv1(0, 1, 5, 0, 0, 0, 0);
    drv1(0, 3, 5, 0, 1, 2, 5);
    want = BYP ? 8'hFF : 8'h00;
    total++;
    if (db1 !== want || wrp1 !== 1'b1 || da1 !== 8'h3D) begin
      bad++; $display("FAIL rw_dec_wrap got %h w%b a%h want %h w1 a3d",
                      db1, wrp1, da1, want);
    end
    drv1(0, 0, 0, 0, 1, 5, 5);
    total++;
    if (da1 !== 8'hFF) begin
      bad++; $display("FAIL rw_next got %h want ff", da1);
    end
  endtask

  task automatic test_random;
    int d;
    for (int k = 0; k < 400; k++) begin
      d = ($urandom_range(0, 3) == 0) ?
          (($urandom_range(0, 1) == 0) ? 0 : 255) :
          int'($urandom_range(0, 255));
      drv1($urandom_range(0, 39) == 0, $urandom_range(0, 3),
           $urandom_range(0, 7), d, $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 7));
      total++;
      if (da1 !== 8'(era[0]) || db1 !== 8'(erb[0]) ||
          vld1 !== ev[0] || wrp1 !== ew[0] || zr1 !== ez[0]) begin
        bad++;
        $display("FAIL rnd k=%0d got %h/%h v%b w%b z%b want %h/%h v%b w%b z%b",
                 k, da1, db1, vld1, wrp1, zr1, 8'(era[0]), 8'(erb[0]),
                 ev[0], ew[0], ez[0]);
      end
    end
  endtask

  task automatic test_out_of_range;
    drv6(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drv6(0, 1, i, i + 1, 0, 0, 0);
    drv6(0, 1, 7, 0, 1, 5, 7);
    total++;
    if (db6 !== 8'h00 || da6 !== 8'h06 || zr6 !== 1'b0) begin
      bad++; $display("FAIL oob_load got b%h a%h z%b want b00 a06 z0",
                      db6, da6, zr6);
    end
    drv6(0, 3, 6, 0, 0, 0, 0);
    total++;
    if (wrp6 !== 1'b0 || zr6 !== 1'b0) begin
      bad++; $display("FAIL oob_dec got w%b z%b want w0 z0", wrp6, zr6);
    end
    for (int i = 0; i < 6; i++) begin
      drv6(0, 0, 0, 0, 1, i, 6);
      total++;
      if (da6 !== 8'(i + 1) || db6 !== 8'h00) begin
        bad++; $display("FAIL oob_keep r%0d got %h/%h want %h/00",
                        i, da6, db6, 8'(i + 1));
      end
    end
    for (int k = 0; k < 300; k++) begin
      drv6($urandom_range(0, 49) == 0, $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 7));
      total++;
      if (da6 !== 8'(era[1]) || db6 !== 8'(erb[1]) ||
          vld6 !== ev[1] || wrp6 !== ew[1] || zr6 !== ez[1]) begin
        bad++;
        $display("FAIL rnd6 k=%0d got %h/%h v%b w%b z%b want %h/%h v%b w%b z%b",
                 k, da6, db6, vld6, wrp6, zr6, 8'(era[1]), 8'(erb[1]),
                 ev[1], ew[1], ez[1]);
      end
    end
  endtask

  task automatic test_wide;
    drvw(1, 0, 0, 0, 0, 0, 0);
    drvw(0, 1, 0, 'h1234, 0, 0, 0);
    drvw(0, 1, 3, 'hBEEF, 0, 0, 0);
    drvw(0, 0, 0, 0, 1, 0, 3);
    total++;
    if (daw !== 16'h1234 || dbw !== 16'hBEEF || vldw !== 1'b1) begin
      bad++; $display("FAIL wide_dual got %h/%h v%b want 1234/beef v1",
                      daw, dbw, vldw);
    end
    for (int k = 0; k < 200; k++) begin
      drvw($urandom_range(0, 49) == 0, $urandom_range(0, 3),
           $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? 'hFFFF :
           int'($urandom_range(0, 65535)),
           $urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 3));
      total++;
      if (daw !== 16'(era[2]) || dbw !== 16'(erb[2]) ||
          vldw !== ev[2] || wrpw !== ew[2] || zrw !== ez[2]) begin
        bad++;
        $display("FAIL rndw k=%0d got %h/%h v%b w%b z%b want %h/%h v%b w%b z%b",
                 k, daw, dbw, vldw, wrpw, zrw, 16'(era[2]), 16'(erb[2]),
                 ev[2], ew[2], ez[2]);
      end
    end
  endtask

  initial begin
    rst1 = 1; op1 = 0; wa1 = 0; wd1 = 0; re1 = 0; ra1 = 0; rb1 = 0;
    rst6 = 1; op6 = 0; wa6 = 0; wd6 = 0; re6 = 0; ra6 = 0; rb6 = 0;
    rstw = 1; opw = 0; waw = 0; wdw = 0; rew = 0; raw = 0; rbw = 0;
    test_reset();
    test_load_read();
    test_wrap();
    test_same_cycle();
    test_random();
    test_out_of_range();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
